// File: rtl/uart_word_tx_if.sv
// FIFO-side handshake and serial outputs of the 32-bit word UART transmitter.
// master = FIFO controller / line monitor, slave = the transmitter.
interface uart_word_tx_if;
  logic        uart_en;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic        word_done;

  modport master (
    output uart_en, fifo_empty, fifo_dout,
    input  fifo_rd_en, tx, busy, word_done
  );

  modport slave (
    input  uart_en, fifo_empty, fifo_dout,
    output fifo_rd_en, tx, busy, word_done
  );
endinterface

// File: rtl/uart_word_tx.sv
// Pulls one 32-bit word from a FIFO and sends it as four 8N1 UART frames,
// most-significant byte first, with no idle gap between frames.
module uart_word_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_word_tx_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} state_t;

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        tx_q, tx_d;
  logic        rd_q, rd_d;
  logic        bit_end;
  logic [4:0]  base_d;
  logic [7:0]  byte_d;

  assign bit_end = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.uart_en && !bus.fifo_empty) state_d = REQ;
      end
      REQ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = '0;
        word_d  = bus.fifo_dout;
        idx_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = START;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so tx and the read strobe
    // line up exactly with the state they belong to.
    base_d = {~idx_d, 3'b000};
    byte_d = word_d[base_d +: 8];
    rd_d   = (state_d == REQ);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.fifo_rd_en = rd_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.word_done  = (state_q == STOP) && bit_end && (idx_q == 2'd3);

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: one instance at BAUD_DIV=4 for protocol
// and sequencing, one at BAUD_DIV=434 for exact bit widths.
module tb_uart_word_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_word_tx_if ia ();
  uart_word_tx_if ib ();

  uart_word_tx #(.BAUD_DIV(4))   dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  uart_word_tx #(.BAUD_DIV(434)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int n_chk  = 0;
  int n_pass = 0;

  logic tx_a [0:599];
  logic rd_a [0:599];
  logic wd_a [0:599];
  logic tx_b [0:17399];
  logic wd_b [0:17399];
  logic [31:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic exp_bit(input logic [31:0] w, input int f, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return w[8*(3-f) + j - 1];
  endfunction

  // Called at a negedge; returns at the negedge where fifo_rd_en is high.
  task automatic wait_rd(input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (ia.fifo_rd_en) return;
      @(negedge clk);
    end
    chk({tag, "_rd_timeout"}, 32'd0, 32'd1);
  endtask

  // Records n cycles starting at the current (read-strobe) negedge, index 0.
  task automatic cap_a(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i == drop_at) ia.uart_en = 1'b0;
      tx_a[i] = ia.tx;
      rd_a[i] = ia.fifo_rd_en;
      wd_a[i] = ia.word_done;
      if (ia.fifo_rd_en) begin
        if (wq.size() > 0) ia.fifo_dout = wq.pop_front();
        if (wq.size() == 0) ia.fifo_empty = 1'b1;
      end
    end
  endtask

  task automatic check_word(input int base, input logic [31:0] w, input string tag);
    logic [7:0] b;
    for (int f = 0; f < 4; f++) begin
      for (int j = 1; j <= 8; j++) b[j-1] = tx_a[base + 4 + 40*f + 4*j];
      chk($sformatf("%s_byte%0d", tag, f), {24'd0, b}, {24'd0, w[8*(3-f) +: 8]});
      chk($sformatf("%s_frame%0d", tag, f),
          {30'd0, tx_a[base + 4 + 40*f], tx_a[base + 4 + 40*f + 36]}, 32'd1);
    end
  endtask

  function automatic int count_rd(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (rd_a[i]) c++;
    return c;
  endfunction

  initial begin
    int bad_rd, bad_tx, bad_busy, bad;
    logic e;
    ia.uart_en = 1'b0; ia.fifo_empty = 1'b1; ia.fifo_dout = '0;
    ib.uart_en = 1'b0; ib.fifo_empty = 1'b1; ib.fifo_dout = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",   {31'd0, ia.tx},         32'd1);
    chk("rst_rd",   {31'd0, ia.fifo_rd_en}, 32'd0);
    chk("rst_busy", {31'd0, ia.busy},       32'd0);
    chk("rst_wd",   {31'd0, ia.word_done},  32'd0);
    rst_n = 1'b1;

    // Empty FIFO with enable high
    ia.uart_en = 1'b1;
    bad_rd = 0; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ia.fifo_rd_en !== 1'b0) bad_rd++;
      if (ia.tx !== 1'b1) bad_tx++;
      if (ia.busy !== 1'b0) bad_busy++;
    end
    chk("empty_rd",   bad_rd,   0);
    chk("empty_tx",   bad_tx,   0);
    chk("empty_busy", bad_busy, 0);

    // Basic word
    wq = {32'hA5C30F81};
    ia.fifo_empty = 1'b0;
    wait_rd("basic");
    cap_a(200, -1);
    chk("basic_tx_wait",  {31'd0, tx_a[1]}, 32'd1);
    chk("basic_tx_start", {31'd0, tx_a[2]}, 32'd0);
    check_word(0, 32'hA5C30F81, "basic");
    chk("basic_wd", {29'd0, wd_a[160], wd_a[161], wd_a[162]}, 32'b010);
    chk("basic_rd_count", count_rd(200), 1);

    // Back-to-back words
    wq = {32'h12345678, 32'hFF00AA55, 32'h0180C3E7};
    ia.fifo_empty = 1'b0;
    wait_rd("b2b");
    cap_a(500, -1);
    chk("b2b_rd_count", count_rd(500), 3);
    chk("b2b_rd_pos", {30'd0, rd_a[163], rd_a[326]}, 32'b11);
    chk("b2b_wd_pos", {29'd0, wd_a[161], wd_a[324], wd_a[487]}, 32'b111);
    check_word(0,   32'h12345678, "b2b_w0");
    check_word(163, 32'hFF00AA55, "b2b_w1");
    check_word(326, 32'h0180C3E7, "b2b_w2");

    // Enable drops during byte 1; a second word stays queued but is never read
    wq = {32'h3CA5F00D, 32'hDEADBEEF};
    ia.fifo_empty = 1'b0;
    ia.uart_en = 1'b1;
    wait_rd("drop");
    cap_a(300, 50);
    check_word(0, 32'h3CA5F00D, "drop");
    chk("drop_wd", {31'd0, wd_a[161]}, 32'd1);
    chk("drop_rd_count", count_rd(300), 1);
    wq.delete();

    // Reset during DATA of byte 2, then a fresh word
    wq = {32'h9E3779B9};
    ia.fifo_empty = 1'b0;
    ia.uart_en = 1'b1;
    wait_rd("rst");
    cap_a(95, -1);
    @(negedge clk);
    chk("rst_mid_busy_before", {31'd0, ia.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx",   {31'd0, ia.tx},   32'd1);
    chk("rst_mid_busy", {31'd0, ia.busy}, 32'd0);
    repeat (2) @(negedge clk);
    wq = {32'hC0FFEE42};
    ia.fifo_empty = 1'b0;
    rst_n = 1'b1;
    wait_rd("rst2");
    cap_a(200, -1);
    check_word(0, 32'hC0FFEE42, "rst_restart");
    chk("rst_restart_rd_count", count_rd(200), 1);
    ia.uart_en = 1'b0;

    // Full-rate bit widths at BAUD_DIV=434
    ib.fifo_dout = 32'h5A3C9612;
    ib.fifo_empty = 1'b0;
    ib.uart_en = 1'b1;
    bad = 1;
    for (int i = 0; i < 1000; i++) begin
      if (ib.fifo_rd_en) begin bad = 0; break; end
      @(negedge clk);
    end
    chk("b434_rd_seen", bad, 0);
    ib.fifo_empty = 1'b1;
    for (int i = 0; i < 17366; i++) begin
      if (i > 0) @(negedge clk);
      tx_b[i] = ib.tx;
      wd_b[i] = ib.word_done;
    end
    chk("b434_tx_wait", {31'd0, tx_b[1]}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      e = exp_bit(32'h5A3C9612, k / 10, k % 10);
      bad = 0;
      for (int c = 0; c < 434; c++) if (tx_b[2 + 434*k + c] !== e) bad++;
      chk($sformatf("b434_bit%0d", k), bad, 0);
    end
    chk("b434_idle_after", {31'd0, tx_b[17362]}, 32'd1);
    chk("b434_wd", {30'd0, wd_b[17361], wd_b[17362]}, 32'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
